// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial N-bit unsigned adder. A single full-adder cell is reused over N
// clock cycles, LSB first, to produce {o_cout, o_sum} = i_a + i_b + i_cin.
// A START/BUSY/DONE handshake launches one addition at a time. The issue
// interval is N+2 cycles.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous, active-high reset
//   i_start  launch request, sampled only in IDLE
//   i_a      operand A, captured on the accepting edge
//   i_b      operand B, captured on the accepting edge
//   i_cin    carry-in, captured on the accepting edge
//   o_busy   high for exactly N cycles while bits are processed
//   o_done   one-cycle pulse; o_sum/o_cout are valid from this cycle
//   o_sum    registered result, held until the next completion
//   o_cout   registered carry-out, held until the next completion
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   localparam int             CW   = $clog2(N + 1);
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic [N-1:0]  r_ra;
   logic [N-1:0]  r_rb;
   logic [N-1:0]  r_rs;
   logic          r_c;
   logic [CW-1:0] r_cnt;

   logic [1:0]    w_y;        // ones count of the three adder inputs
   logic [N-1:0]  w_rs_next;  // result register after this bit enters
   logic          w_last;     // current edge processes the final bit

   // Full-adder cell: sum bit is the count LSB, carry is the count MSB.
   assign w_y       = {1'b0, r_ra[0]} + {1'b0, r_rb[0]} + {1'b0, r_c};
   // Shift right, new sum bit enters at the MSB; after N shifts the LSB
   // computed first has arrived at bit 0.
   assign w_rs_next = {w_y[0], {(N-1){1'b0}}} | (r_rs >> 1);
   assign w_last    = (r_cnt == LAST);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // NOTE: the default assignment up front guarantees every path drives
   // w_next, so no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_SHIFT;
         S_SHIFT: if (w_last)  w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;   // START is ignored here
         default: w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode, directly from the state register (glitch-free)
   // ------------------------------------------------------------------
   always_comb begin
      o_busy = (r_state == S_SHIFT);
      o_done = (r_state == S_DONE);
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ra   <= '0;
         r_rb   <= '0;
         r_rs   <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         o_sum  <= '0;
         o_cout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_ra  <= i_a;
                  r_rb  <= i_b;
                  r_c   <= i_cin;
                  r_cnt <= '0;
               end
            end
            S_SHIFT: begin
               r_rs  <= w_rs_next;
               r_c   <= w_y[1];
               r_ra  <= r_ra >> 1;
               r_rb  <= r_rb >> 1;
               r_cnt <= r_cnt + CW'(1);
               // Results are published only on the completion edge so the
               // host never sees a partially shifted value.
               if (w_last) begin
                  o_sum  <= w_rs_next;
                  o_cout <= w_y[1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl. Two instances: N=8 for the
// functional/timing sequences and N=2 for the exhaustive sweep. Expected
// results are pushed to per-instance queues when an operation is launched
// and popped by a monitor when DONE is observed.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst;

   // N = 8 instance
   logic       start8;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   // N = 2 instance
   logic       start2;
   logic [1:0] a2, b2;
   logic       cin2;
   logic       busy2, done2, cout2;
   logic [1:0] sum2;

   int         n_vec  = 0;
   int         n_fail = 0;
   int         n_done8 = 0;

   logic [8:0] q8[$];
   logic [2:0] q2[$];
   logic [8:0] prev8;   // result the N=8 outputs must hold mid-operation

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[6];

   serial_add_ctrl #(.N(8)) u_dut8 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start8),
      .i_a     (a8),
      .i_b     (b8),
      .i_cin   (cin8),
      .o_busy  (busy8),
      .o_done  (done8),
      .o_sum   (sum8),
      .o_cout  (cout8)
   );

   serial_add_ctrl #(.N(2)) u_dut2 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start2),
      .i_a     (a2),
      .i_b     (b2),
      .i_cin   (cin2),
      .o_busy  (busy2),
      .o_done  (done2),
      .o_sum   (sum2),
      .o_cout  (cout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Scoreboard monitors: compare the result on every DONE pulse.
   always @(negedge clk) begin
      if (!rst && done8) begin
         n_done8++;
         if (q8.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_done8: DONE=1 with no operation outstanding, expected DONE=0 (t=%0t)", $time);
         end else begin
            check("result8", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
         end
         check("busy_in_done8", {31'd0, busy8}, 32'd0);
      end
      if (!rst && done2) begin
         if (q2.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_done2: DONE=1 with no operation outstanding, expected DONE=0 (t=%0t)", $time);
         end else begin
            check("result2", {29'd0, cout2, sum2}, {29'd0, q2.pop_front()});
         end
      end
   end

   // Launch one N=8 operation and follow it to idle. Entered and left at a
   // negative clock edge.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [8:0] exp);
      int nb;
      a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
      q8.push_back(exp);
      @(posedge clk);           // edge 0: accept
      @(negedge clk);
      start8 = 1'b0;
      a8 = ~a; b8 = ~b; cin8 = ~cin;   // operands may change after accept
      nb = 0;
      while (busy8 && nb < 40) begin
         check("hold_result8", {23'd0, cout8, sum8}, {23'd0, prev8});
         nb++;
         tick();
      end
      check("busy_len8", nb, 8);
      check("done_pulse8", {31'd0, done8}, 32'd1);
      prev8 = exp;
      tick();
      check("done_width8", {31'd0, done8}, 32'd0);
      check("idle_busy8", {31'd0, busy8}, 32'd0);
   endtask

   task automatic run_op2(input logic [1:0] a, input logic [1:0] b,
                          input logic cin, input logic [2:0] exp);
      int nb;
      a2 = a; b2 = b; cin2 = cin; start2 = 1'b1;
      q2.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      nb = 0;
      while (busy2 && nb < 20) begin
         nb++;
         tick();
      end
      check("busy_len2", nb, 2);
      check("done_pulse2", {31'd0, done2}, 32'd1);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, exp: 9'h096};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp: 9'h100};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp: 9'h1FF};
      vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp: 9'h001};
      vecs[4] = '{a: 8'h80, b: 8'h7F, cin: 1'b0, exp: 9'h0FF};
      vecs[5] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, exp: 9'h100};

      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      prev8 = '0;

      // ---- Reset state ----
      repeat (2) @(negedge clk);
      check("rst_busy8", {31'd0, busy8}, 32'd0);
      check("rst_done8", {31'd0, done8}, 32'd0);
      check("rst_result8", {23'd0, cout8, sum8}, 32'd0);
      check("rst_result2", {29'd0, cout2, sum2}, 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_busy8", {31'd0, busy8}, 32'd0);
      check("post_rst_done8", {31'd0, done8}, 32'd0);

      // ---- Table-driven single operations ----
      for (int i = 0; i < 6; i++) begin
         run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
      end

      // ---- Ignored START during SHIFT and DONE ----
      begin
         int base;
         int w;
         base = n_done8;
         a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
         q8.push_back(9'h003);
         @(posedge clk);
         @(negedge clk);
         start8 = 1'b0;
         repeat (3) tick();
         start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F;
         tick();
         start8 = 1'b0;
         w = 0;
         while (!done8 && w < 40) begin
            w++;
            tick();
         end
         check("ign_done_seen", {31'd0, done8}, 32'd1);
         start8 = 1'b1;          // sampled in DONE: must be ignored
         tick();
         start8 = 1'b0;
         repeat (20) tick();
         check("ign_done_count", n_done8 - base, 1);
         check("ign_result", {23'd0, cout8, sum8}, 32'h003);
         check("ign_idle_busy", {31'd0, busy8}, 32'd0);
         prev8 = 9'h003;
      end

      // ---- Reset mid-operation ----
      run_op8(8'h5A, 8'h3C, 1'b0, 9'h096);
      a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
      q8.push_back(9'h033);
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) begin
         check("midrst_hold", {23'd0, cout8, sum8}, 32'h096);
         tick();
      end
      rst = 1'b1;
      q8.delete();             // aborted operation yields no result
      #1;
      check("midrst_busy", {31'd0, busy8}, 32'd0);
      check("midrst_done", {31'd0, done8}, 32'd0);
      check("midrst_result", {23'd0, cout8, sum8}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      prev8 = '0;
      tick();
      check("midrst_idle", {31'd0, busy8}, 32'd0);
      run_op8(8'h11, 8'h22, 1'b0, 9'h033);

      // ---- Back-to-back with START held high ----
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      q8.push_back(9'h100);
      @(posedge clk);          // edge 0
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);       // observing the state after edge k
         if (k == 0) begin
            a8 = 8'h7F; b8 = 8'h01;
            q8.push_back(9'h080);
         end
         check($sformatf("b2b_busy_e%0d", k), {31'd0, busy8},
               ((k <= 7) || (k >= 10 && k <= 17)) ? 32'd1 : 32'd0);
         check($sformatf("b2b_done_e%0d", k), {31'd0, done8},
               (k == 8 || k == 18) ? 32'd1 : 32'd0);
         if (k == 18) start8 = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      prev8 = 9'h080;

      // ---- Exhaustive sweep, N = 2 ----
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 2; c++) begin
               logic [2:0] e;
               e = 3'(a) + 3'(b) + 3'(c);
               run_op2(2'(a), 2'(b), 1'(c), e);
            end
         end
      end

      repeat (4) tick();
      check("sb_empty8", q8.size(), 0);
      check("sb_empty2", q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
